// File: rtl/timestamp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timestamp_pkg : shared record type for the event timestamper         |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package timestamp_pkg;

   localparam int TS_W = 32;

   // "time" is reserved in SystemVerilog, hence tstamp
   typedef struct packed {
      logic [TS_W-1:0] tstamp;
      logic [TS_W-1:0] period;
      logic            first;
   } ts_rec_t;

endpackage
`default_nettype wire

// File: rtl/ts_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ts_fifo  : synchronous show-ahead FIFO of timestamp records          |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module ts_fifo
   import timestamp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   CLOCK,
   input  logic                   RST,
   input  logic                   i_push,
   input  ts_rec_t                i_data,
   input  logic                   i_pop,
   output ts_rec_t                o_data,
   output logic                   o_valid,
   output logic                   o_push_ok,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int            c_AW  = $clog2(DEPTH);
   localparam logic [c_AW:0] c_ONE = 1;

   ts_rec_t       r_mem [DEPTH];
   logic [c_AW:0] r_wr_ptr;
   logic [c_AW:0] r_rd_ptr;
   logic          w_empty;
   logic          w_full;
   logic          w_do_pop;
   logic          w_do_push;

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign w_do_pop  = i_pop & ~w_empty;
   // A pop frees the slot being written, so a full FIFO still accepts
   assign o_push_ok = ~w_full | w_do_pop;
   assign w_do_push = i_push & o_push_ok;

   always_ff @(posedge CLOCK) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
            r_wr_ptr                  <= r_wr_ptr + c_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ONE;
         end
      end
   end

   // Head is taken straight from the storage flops
   assign o_data  = r_mem[r_rd_ptr[c_AW-1:0]];
   assign o_valid = ~w_empty;
   assign o_level = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/event_timestamper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | event_timestamper : timestamps EVENT rising edges, measures periods  |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module event_timestamper
   import timestamp_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   CLOCK,
   input  logic                   RST,
   input  logic [TS_W-1:0]        COUNTER,
   input  logic                   EVENT,
   input  logic                   ENABLE,
   input  logic                   TS_READY,
   input  logic                   CLR_OVF,
   output logic                   TS_VALID,
   output logic [TS_W-1:0]        TS_TIME,
   output logic [TS_W-1:0]        TS_PERIOD,
   output logic                   TS_FIRST,
   output logic [$clog2(DEPTH):0] LEVEL,
   output logic                   OVERFLOW
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_armed;
   logic                   r_overflow;
   logic [TS_W-1:0]        r_last_time;
   logic                   w_edge;
   logic                   w_push_ok;
   ts_rec_t                w_rec;
   ts_rec_t                w_head;

   assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev & ENABLE;

   always_comb begin
      w_rec        = '0;
      w_rec.tstamp = COUNTER;
      w_rec.first  = r_armed;
      w_rec.period = r_armed ? '0 : (COUNTER - r_last_time);
   end

   always_ff @(posedge CLOCK) begin
      if (RST) begin
         r_sync      <= '0;
         r_prev      <= 1'b0;
         r_armed     <= 1'b1;
         r_overflow  <= 1'b0;
         r_last_time <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], EVENT};
         r_prev <= r_sync[SYNC_STAGES-1];
         // A dropped record still advances the period reference
         if (w_edge) begin
            r_last_time <= COUNTER;
         end
         if (!ENABLE) begin
            r_armed <= 1'b1;
         end else if (w_edge) begin
            r_armed <= 1'b0;
         end
         if (w_edge && !w_push_ok) begin
            r_overflow <= 1'b1;
         end else if (CLR_OVF) begin
            r_overflow <= 1'b0;
         end
      end
   end

   ts_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLOCK     (CLOCK),
      .RST       (RST),
      .i_push    (w_edge),
      .i_data    (w_rec),
      .i_pop     (TS_READY),
      .o_data    (w_head),
      .o_valid   (TS_VALID),
      .o_push_ok (w_push_ok),
      .o_level   (LEVEL)
   );

   assign TS_TIME   = w_head.tstamp;
   assign TS_PERIOD = w_head.period;
   assign TS_FIRST  = w_head.first;
   assign OVERFLOW  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_event_timestamper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_event_timestamper : scoreboard bench for event_timestamper        |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
module tb_event_timestamper;
   import timestamp_pkg::*;

   localparam int DEPTH = 4;
   localparam int SS    = 2;

   logic        CLOCK = 1'b0;
   logic        RST = 1'b1;
   logic        EVENT = 1'b0;
   logic        ENABLE = 1'b1;
   logic        TS_READY = 1'b0;
   logic        CLR_OVF = 1'b0;
   logic        TS_VALID;
   logic [31:0] TS_TIME;
   logic [31:0] TS_PERIOD;
   logic        TS_FIRST;
   logic [2:0]  LEVEL;
   logic        OVERFLOW;

   logic [31:0] tb_cnt = '0;
   logic        cnt_ld = 1'b0;
   logic [31:0] cnt_ld_val = '0;

   logic [31:0] m_last = '0;
   logic        m_armed = 1'b1;
   ts_rec_t     q[$];
   int          n_checks = 0;
   int          n_fail = 0;

   event_timestamper #(
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SS)
   ) dut (
      .CLOCK     (CLOCK),
      .RST       (RST),
      .COUNTER   (tb_cnt),
      .EVENT     (EVENT),
      .ENABLE    (ENABLE),
      .TS_READY  (TS_READY),
      .CLR_OVF   (CLR_OVF),
      .TS_VALID  (TS_VALID),
      .TS_TIME   (TS_TIME),
      .TS_PERIOD (TS_PERIOD),
      .TS_FIRST  (TS_FIRST),
      .LEVEL     (LEVEL),
      .OVERFLOW  (OVERFLOW)
   );

   always #5 CLOCK = ~CLOCK;

   always @(posedge CLOCK) tb_cnt <= cnt_ld ? cnt_ld_val : tb_cnt + 32'd1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Called at a negedge; the model forgets history along with the DUT
   task automatic do_reset(input int cycles);
      RST = 1'b1;
      repeat (cycles) @(negedge CLOCK);
      RST = 1'b0;
      m_last  = '0;
      m_armed = 1'b1;
      q.delete();
   endtask

   // Raises EVENT for one sampled cycle; the record carries COUNTER at
   // the edge SS cycles after the first sample.
   task automatic ev_edge(input bit accepted);
      ts_rec_t e;
      e.tstamp = tb_cnt + 32'(SS);
      e.first  = m_armed;
      e.period = m_armed ? 32'd0 : e.tstamp - m_last;
      m_last   = e.tstamp;
      m_armed  = 1'b0;
      if (accepted) q.push_back(e);
      EVENT = 1'b1;
      @(negedge CLOCK);
      EVENT = 1'b0;
      @(negedge CLOCK);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(negedge CLOCK);
      n_checks++;
      if ({TS_VALID, TS_TIME, TS_PERIOD, TS_FIRST, LEVEL, OVERFLOW} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b t=%h p=%h f=%b l=%0d o=%b, want all 0",
                  TS_VALID, TS_TIME, TS_PERIOD, TS_FIRST, LEVEL, OVERFLOW);
      end
   endtask

   task automatic test_single_edge();
      cnt_ld = 1'b1; cnt_ld_val = 32'd1; RST = 1'b1;
      @(negedge CLOCK);
      cnt_ld = 1'b0;
      @(negedge CLOCK);
      RST = 1'b0; m_last = '0; m_armed = 1'b1; q.delete();
      repeat (8) @(negedge CLOCK);
      ev_edge(1'b1);
      n_checks++;
      if (TS_VALID !== 1'b0) begin
         n_fail++;
         $display("FAIL single_latency: TS_VALID=%b before posedge 12, want 0", TS_VALID);
      end
      @(negedge CLOCK);
      n_checks++;
      if ({TS_VALID, TS_TIME, TS_PERIOD, TS_FIRST, LEVEL} !== {1'b1, 32'd12, 32'd0, 1'b1, 3'd1}) begin
         n_fail++;
         $display("FAIL single_record: got v=%b t=%0d p=%0d f=%b l=%0d, want v=1 t=12 p=0 f=1 l=1",
                  TS_VALID, TS_TIME, TS_PERIOD, TS_FIRST, LEVEL);
      end
      void'(q.pop_front());
      TS_READY = 1'b1;
      @(negedge CLOCK);
      TS_READY = 1'b0;
      n_checks++;
      if (TS_VALID !== 1'b0 || LEVEL !== 3'd0) begin
         n_fail++;
         $display("FAIL single_pop: got v=%b l=%0d, want v=0 l=0", TS_VALID, LEVEL);
      end
   endtask

   task automatic test_period();
      do_reset(1);
      repeat (3) @(negedge CLOCK);
      TS_READY = 1'b1;
      fork
         begin
            ev_edge(1'b1);
            repeat (18) @(negedge CLOCK);
            ev_edge(1'b1);
            repeat (23) @(negedge CLOCK);
            ev_edge(1'b1);
         end
         begin
            for (int i = 0; i < 3; i++) begin
               ts_rec_t e;
               int      w;
               logic [31:0] cp;
               w = 0;
               while (TS_VALID !== 1'b1 && w < 60) begin @(negedge CLOCK); w++; end
               e  = (q.size() != 0) ? q.pop_front() : '0;
               cp = (i == 0) ? 32'd0 : (i == 1) ? 32'd20 : 32'd25;
               n_checks++;
               if (TS_VALID !== 1'b1 || {TS_TIME, TS_PERIOD, TS_FIRST} !== e) begin
                  n_fail++;
                  $display("FAIL period_rec%0d: got v=%b t=%h p=%h f=%b, want t=%h p=%h f=%b",
                           i, TS_VALID, TS_TIME, TS_PERIOD, TS_FIRST, e.tstamp, e.period, e.first);
               end
               n_checks++;
               if (TS_PERIOD !== cp || TS_FIRST !== (i == 0)) begin
                  n_fail++;
                  $display("FAIL period_value%0d: got p=%0d f=%b, want p=%0d f=%b",
                           i, TS_PERIOD, TS_FIRST, cp, (i == 0));
               end
               @(negedge CLOCK);
            end
         end
      join
      TS_READY = 1'b0;
   endtask

   task automatic test_wrap();
      ts_rec_t e;
      int      w;
      cnt_ld = 1'b1; cnt_ld_val = 32'hFFFF_FFF0;
      @(negedge CLOCK);
      cnt_ld = 1'b0;
      ev_edge(1'b1);
      repeat (30) @(negedge CLOCK);
      ev_edge(1'b1);
      TS_READY = 1'b1;
      for (int i = 0; i < 2; i++) begin
         w = 0;
         while (TS_VALID !== 1'b1 && w < 40) begin @(negedge CLOCK); w++; end
         e = (q.size() != 0) ? q.pop_front() : '0;
         n_checks++;
         if (TS_VALID !== 1'b1 || {TS_TIME, TS_PERIOD, TS_FIRST} !== e) begin
            n_fail++;
            $display("FAIL wrap_rec%0d: got v=%b t=%h p=%h f=%b, want t=%h p=%h f=%b",
                     i, TS_VALID, TS_TIME, TS_PERIOD, TS_FIRST, e.tstamp, e.period, e.first);
         end
         if (i == 1) begin
            n_checks++;
            if (TS_TIME !== 32'h12 || TS_PERIOD !== 32'h20) begin
               n_fail++;
               $display("FAIL wrap_period: got t=%h p=%h, want t=00000012 p=00000020",
                        TS_TIME, TS_PERIOD);
            end
         end
         @(negedge CLOCK);
      end
      TS_READY = 1'b0;
   endtask

   task automatic test_overflow();
      ts_rec_t e;
      int      w;
      for (int i = 0; i < 5; i++) begin
         ev_edge(i < 4);
         @(negedge CLOCK);
      end
      repeat (3) @(negedge CLOCK);
      n_checks++;
      if (LEVEL !== 3'd4 || OVERFLOW !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_full: got l=%0d o=%b, want l=4 o=1", LEVEL, OVERFLOW);
      end
      TS_READY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         w = 0;
         while (TS_VALID !== 1'b1 && w < 40) begin @(negedge CLOCK); w++; end
         e = (q.size() != 0) ? q.pop_front() : '0;
         n_checks++;
         if (TS_VALID !== 1'b1 || {TS_TIME, TS_PERIOD, TS_FIRST} !== e) begin
            n_fail++;
            $display("FAIL ovf_drain%0d: got v=%b t=%h p=%h f=%b, want t=%h p=%h f=%b",
                     i, TS_VALID, TS_TIME, TS_PERIOD, TS_FIRST, e.tstamp, e.period, e.first);
         end
         @(negedge CLOCK);
      end
      n_checks++;
      if (TS_VALID !== 1'b0 || OVERFLOW !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_after_drain: got v=%b o=%b, want v=0 o=1", TS_VALID, OVERFLOW);
      end
      ev_edge(1'b1);
      w = 0;
      while (TS_VALID !== 1'b1 && w < 40) begin @(negedge CLOCK); w++; end
      e = (q.size() != 0) ? q.pop_front() : '0;
      n_checks++;
      if (TS_VALID !== 1'b1 || {TS_TIME, TS_PERIOD, TS_FIRST} !== e) begin
         n_fail++;
         $display("FAIL ovf_next_period: got v=%b t=%h p=%h f=%b, want t=%h p=%h f=%b",
                  TS_VALID, TS_TIME, TS_PERIOD, TS_FIRST, e.tstamp, e.period, e.first);
      end
      @(negedge CLOCK);
      TS_READY = 1'b0;
      CLR_OVF  = 1'b1;
      @(negedge CLOCK);
      CLR_OVF  = 1'b0;
      n_checks++;
      if (OVERFLOW !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear: got o=%b, want 0", OVERFLOW);
      end
   endtask

   task automatic test_full_pop();
      ts_rec_t e;
      int      w;
      for (int i = 0; i < 4; i++) begin
         ev_edge(1'b1);
         @(negedge CLOCK);
      end
      repeat (2) @(negedge CLOCK);
      n_checks++;
      if (LEVEL !== 3'd4) begin
         n_fail++;
         $display("FAIL fullpop_fill: got l=%0d, want 4", LEVEL);
      end
      ev_edge(1'b1);
      e = (q.size() != 0) ? q.pop_front() : '0;
      n_checks++;
      if (TS_VALID !== 1'b1 || {TS_TIME, TS_PERIOD, TS_FIRST} !== e) begin
         n_fail++;
         $display("FAIL fullpop_head: got v=%b t=%h p=%h f=%b, want t=%h p=%h f=%b",
                  TS_VALID, TS_TIME, TS_PERIOD, TS_FIRST, e.tstamp, e.period, e.first);
      end
      TS_READY = 1'b1;
      @(negedge CLOCK);
      TS_READY = 1'b0;
      n_checks++;
      if (LEVEL !== 3'd4 || OVERFLOW !== 1'b0) begin
         n_fail++;
         $display("FAIL fullpop_accept: got l=%0d o=%b, want l=4 o=0", LEVEL, OVERFLOW);
      end
      ev_edge(1'b0);
      CLR_OVF = 1'b1;
      @(negedge CLOCK);
      CLR_OVF = 1'b0;
      n_checks++;
      if (OVERFLOW !== 1'b1 || LEVEL !== 3'd4) begin
         n_fail++;
         $display("FAIL clr_vs_set: got o=%b l=%0d, want o=1 l=4", OVERFLOW, LEVEL);
      end
      TS_READY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         w = 0;
         while (TS_VALID !== 1'b1 && w < 40) begin @(negedge CLOCK); w++; end
         e = (q.size() != 0) ? q.pop_front() : '0;
         n_checks++;
         if (TS_VALID !== 1'b1 || {TS_TIME, TS_PERIOD, TS_FIRST} !== e) begin
            n_fail++;
            $display("FAIL fullpop_drain%0d: got v=%b t=%h p=%h f=%b, want t=%h p=%h f=%b",
                     i, TS_VALID, TS_TIME, TS_PERIOD, TS_FIRST, e.tstamp, e.period, e.first);
         end
         @(negedge CLOCK);
      end
      TS_READY = 1'b0;
      CLR_OVF  = 1'b1;
      @(negedge CLOCK);
      CLR_OVF  = 1'b0;
   endtask

   task automatic test_enable_reset();
      ts_rec_t e;
      int      w;
      ENABLE = 1'b0; m_armed = 1'b1; EVENT = 1'b1;
      repeat (4) @(negedge CLOCK);
      ENABLE = 1'b1;
      repeat (4) @(negedge CLOCK);
      n_checks++;
      if (TS_VALID !== 1'b0 || LEVEL !== 3'd0) begin
         n_fail++;
         $display("FAIL enable_rise_high: got v=%b l=%0d, want v=0 l=0", TS_VALID, LEVEL);
      end
      EVENT = 1'b0;
      repeat (2) @(negedge CLOCK);
      ev_edge(1'b1);
      repeat (3) @(negedge CLOCK);
      ev_edge(1'b1);
      repeat (3) @(negedge CLOCK);
      ENABLE = 1'b0; m_armed = 1'b1;
      repeat (3) @(negedge CLOCK);
      ENABLE = 1'b1;
      repeat (2) @(negedge CLOCK);
      ev_edge(1'b1);
      TS_READY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         w = 0;
         while (TS_VALID !== 1'b1 && w < 40) begin @(negedge CLOCK); w++; end
         e = (q.size() != 0) ? q.pop_front() : '0;
         n_checks++;
         if (TS_VALID !== 1'b1 || {TS_TIME, TS_PERIOD, TS_FIRST} !== e ||
             TS_FIRST !== (i != 1)) begin
            n_fail++;
            $display("FAIL enable_rec%0d: got v=%b t=%h p=%h f=%b, want t=%h p=%h f=%b",
                     i, TS_VALID, TS_TIME, TS_PERIOD, TS_FIRST, e.tstamp, e.period, e.first);
         end
         @(negedge CLOCK);
      end
      TS_READY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ev_edge(1'b1);
         @(negedge CLOCK);
      end
      repeat (2) @(negedge CLOCK);
      n_checks++;
      if (LEVEL !== 3'd3) begin
         n_fail++;
         $display("FAIL level3: got l=%0d, want 3", LEVEL);
      end
      do_reset(1);
      n_checks++;
      if ({TS_VALID, TS_TIME, TS_PERIOD, TS_FIRST, LEVEL, OVERFLOW} !== '0) begin
         n_fail++;
         $display("FAIL reset_level3: got v=%b t=%h p=%h f=%b l=%0d o=%b, want all 0",
                  TS_VALID, TS_TIME, TS_PERIOD, TS_FIRST, LEVEL, OVERFLOW);
      end
      // EVENT held high across reset release yields exactly one record
      EVENT = 1'b1;
      do_reset(2);
      e.tstamp = tb_cnt + 32'(SS);
      e.period = 32'd0;
      e.first  = 1'b1;
      q.push_back(e);
      repeat (6) @(negedge CLOCK);
      n_checks++;
      if (LEVEL !== 3'd1) begin
         n_fail++;
         $display("FAIL held_event_count: got l=%0d, want 1", LEVEL);
      end
      e = (q.size() != 0) ? q.pop_front() : '0;
      n_checks++;
      if (TS_VALID !== 1'b1 || {TS_TIME, TS_PERIOD, TS_FIRST} !== e) begin
         n_fail++;
         $display("FAIL held_event_rec: got v=%b t=%h p=%h f=%b, want t=%h p=%h f=%b",
                  TS_VALID, TS_TIME, TS_PERIOD, TS_FIRST, e.tstamp, e.period, e.first);
      end
      EVENT = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_edge();
      test_period();
      test_wrap();
      test_overflow();
      test_full_pop();
      test_enable_reset();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
